id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage for the pipelined MIPS core.
- Sits between the IF/ID and EX boundaries. It decodes a 32-bit MIPS instruction and reads two operands from an internal register file.
- Write-back data is bypassed into the read path in the same cycle.
- Load-use hazards are detected and a bubble is inserted. Results are held in an ID/EX pipeline register with a valid/ready handshake and flush.

Parameters:
- DATA_W, 32: register and immediate width (≥16).
- REG_COUNT, 32: number of architectural registers (power of 2, ≥2). ADDR_W = $clog2(REG_COUNT).
- ZEXT_LOGIC, 1: when 1, the immediate is zero-extended for andi/ori/xori. When 0, every immediate is sign-extended.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- if_valid, in, 1: instruction is valid.
- if_ready, out, 1: stage accepts the instruction this cycle.
- instruction, in, 32: instruction word.
- wb_reg_write, in, 1: write-back enable.
- wb_write_reg, in, ADDR_W: write-back destination register.
- wb_write_data, in, DATA_W: write-back data.
- flush, in, 1: discard the in-flight ID/EX contents and the incoming instruction.
- ex_ready, in, 1: EX accepts the current ID/EX contents.
- ex_valid, out, 1: ID/EX register holds a valid instruction.
- ex_read_data_1, out, DATA_W: rs operand.
- ex_read_data_2, out, DATA_W: rt operand.
- ex_imm, out, DATA_W: extended immediate.
- ex_rs, out, ADDR_W: rs field. ex_rt, out, ADDR_W: rt field. ex_rd, out, ADDR_W: rd field.
- ex_opcode, out, 6: opcode field. ex_funct, out, 6: funct field.
- ex_mem_read, out, 1: instruction is a lw (opcode 6'h23).
- load_use_stall, out, 1: hazard bubble is being inserted this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers and all ex_* outputs clear to 0; ex_valid=0.
  - Reset mid-operation discards the in-flight instruction.
- Register file:
  - REG_COUNT x DATA_W, written on the rising edge when wb_reg_write=1 and wb_write_reg≠0.
  - Register 0 always reads 0.
  - Write-back proceeds regardless of stall, flush or ex_ready.
- Decode:
  - rs=instr[25:21], rt=[20:16], rd=[15:11], truncated to ADDR_W when REG_COUNT<32.
  - opcode=[31:26], funct=[5:0].
  - imm[15:0] is sign-extended to DATA_W. With ZEXT_LOGIC=1 and opcode 0x0C/0x0D/0x0E, it is zero-extended instead.
- Bypass:
  - Applies combinationally when wb_reg_write=1, wb_write_reg≠0 and wb_write_reg equals the read address.
  - The read returns wb_write_data, not the stale array value; this is the write-before-read rule.
- Load enable: load_en = !ex_valid || ex_ready.
- Hazard:
  - hazard = ex_valid && ex_mem_read && ex_rt≠0 && (ex_rt==rs || ex_rt==rt) && if_valid.
  - load_use_stall = hazard && load_en && !flush.
- if_ready = flush || (load_en && !hazard).
- Next state on a rising edge, evaluated in priority order:
  1. flush=1: ex_valid←0. The incoming instruction is consumed and dropped. Flush overrides a stall.
  2. Else if load_en=0: the ID/EX register holds all fields.
  3. Else if hazard: bubble is inserted. ex_valid←0 and the instruction stays at the input (if_ready=0). On the next cycle the lw has moved on, so ex_valid would no longer hold it and the instruction is accepted.
  4. Else if if_valid: capture decoded fields and bypassed operands; ex_valid←1.
  5. Else: ex_valid←0. Data fields may hold their previous values.
- Latency: 1 cycle from if_valid&&if_ready to ex_valid. Throughput is 1 instruction per cycle with no hazards.
- Outputs are registered except if_ready and load_use_stall.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants: OP_RTYPE=0x00, OP_LW=0x23, OP_SW=0x2B, OP_ADDI=0x08, OP_ANDI=0x0C, OP_ORI=0x0D, OP_XORI=0x0E.
  - Instruction field position constants.
- Natural sub-module: reg_file, parametrised by DATA_W and REG_COUNT.
  - Two asynchronous read ports and one synchronous write port.
  - Bypass logic is included inside it.
  - Clocked by clk and reset by rst_n.

Test Plan:
- Reset, then write reg 9=5 and reg 10=3. Present 0x012A4020 (add $8,$9,$10) with ex_ready=1.
  -> Next cycle: ex_valid=1, rd_1=5, rd_2=3, ex_rd=8, ex_rs=9, ex_rt=10, funct=0x20.
- Present 0x012A4020 while wb_reg_write=1, wb_write_reg=9, wb_write_data=7 in the same cycle.
  -> ex_read_data_1=7 (bypass); reg 9 reads 7 afterwards.
- Present 0x8D090004 (lw $9,4($8)) followed by 0x012A4020.
  -> The cycle after the lw is captured: load_use_stall=1, if_ready=0.
  -> Next edge: ex_valid=0 (bubble).
  -> Following edge: add is captured, ex_valid=1.
- Present 0x2008FFFD (addi $8,$0,-3) -> ex_imm=0xFFFFFFFD, rd_1=0.
- Present 0x3108FFFF (andi) with ZEXT_LOGIC=1 -> ex_imm=0x0000FFFF.
- Backpressure and flush:
  - Hold ex_ready=0 with ex_valid=1 -> ex_* stable and if_ready=0.
  - Assert flush -> ex_valid=0 next edge and if_ready=1.
  - Assert rst_n=0 mid-stream -> all ex_* outputs are 0 immediately.
- Write reg 0=0xDEAD -> reads of $0 return 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode values, instruction field positions and small decode helpers.
package mips_pkg;

   localparam int unsigned INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RS_MSB     = 25;
   localparam int unsigned RS_LSB     = 21;
   localparam int unsigned RT_MSB     = 20;
   localparam int unsigned RT_LSB     = 16;
   localparam int unsigned RD_MSB     = 15;
   localparam int unsigned RD_LSB     = 11;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned IMM_LSB    = 0;
   localparam int unsigned FUNCT_MSB  = 5;
   localparam int unsigned FUNCT_LSB  = 0;

   // Logical-immediate opcodes, the only ones eligible for zero extension.
   function automatic logic is_logic_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/id_stage_pipelined_reg_file.sv
// Register file with two async read ports, one sync write port and write-before-read bypass.
module reg_file #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 32,
   localparam int unsigned ADDR_W   = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a_c,
   output logic [DATA_W-1:0] rdata_b_c,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [REG_COUNT];
   logic              wr_active;

   assign wr_active = we && (waddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[ADDR_W'(i)] <= '0;
         end
      end else if (wr_active) begin
         regs[waddr] <= wdata;
      end
   end

   // Register 0 is hardwired to zero; a same-cycle write wins over the stored value.
   always_comb begin
      rdata_a_c = regs[raddr_a];
      if (raddr_a == '0) begin
         rdata_a_c = '0;
      end else if (wr_active && (waddr == raddr_a)) begin
         rdata_a_c = wdata;
      end
   end

   always_comb begin
      rdata_b_c = regs[raddr_b];
      if (raddr_b == '0) begin
         rdata_b_c = '0;
      end else if (wr_active && (waddr == raddr_b)) begin
         rdata_b_c = wdata;
      end
   end

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: decode, operand read with bypass, load-use bubble, ID/EX register.
module id_stage_pipelined
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_COUNT  = 32,
   parameter bit          ZEXT_LOGIC = 1'b1,
   localparam int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               wb_reg_write,
   input  logic [ADDR_W-1:0]  wb_write_reg,
   input  logic [DATA_W-1:0]  wb_write_data,
   input  logic               flush,
   input  logic               ex_ready,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_read_data_1,
   output logic [DATA_W-1:0]  ex_read_data_2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [ADDR_W-1:0]  ex_rs,
   output logic [ADDR_W-1:0]  ex_rt,
   output logic [ADDR_W-1:0]  ex_rd,
   output logic [5:0]         ex_opcode,
   output logic [5:0]         ex_funct,
   output logic               ex_mem_read,
   output logic               load_use_stall
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic signed [15:0] imm_raw;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] rdata_1_c;
   logic [DATA_W-1:0] rdata_2_c;
   logic              load_en;
   logic              hazard;

   assign opcode  = instruction[OPCODE_MSB:OPCODE_LSB];
   assign funct   = instruction[FUNCT_MSB:FUNCT_LSB];
   assign rs      = ADDR_W'(instruction[RS_MSB:RS_LSB]);
   assign rt      = ADDR_W'(instruction[RT_MSB:RT_LSB]);
   assign rd      = ADDR_W'(instruction[RD_MSB:RD_LSB]);
   assign imm_raw = signed'(instruction[IMM_MSB:IMM_LSB]);

   always_comb begin
      imm_ext = DATA_W'(imm_raw);
      if (ZEXT_LOGIC && is_logic_imm(opcode)) begin
         imm_ext = DATA_W'(instruction[IMM_MSB:IMM_LSB]);
      end
   end

   reg_file #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT)
   ) u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .raddr_a   (rs),
      .raddr_b   (rt),
      .rdata_a_c (rdata_1_c),
      .rdata_b_c (rdata_2_c),
      .we        (wb_reg_write),
      .waddr     (wb_write_reg),
      .wdata     (wb_write_data)
   );

   // A lw sitting in ID/EX whose target feeds the incoming instruction needs one bubble.
   assign load_en        = !ex_valid || ex_ready;
   assign hazard         = ex_valid && ex_mem_read && (ex_rt != '0) &&
                           ((ex_rt == rs) || (ex_rt == rt)) && if_valid;
   assign load_use_stall = hazard && load_en && !flush;
   assign if_ready       = flush || (load_en && !hazard);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         ex_read_data_1 <= '0;
         ex_read_data_2 <= '0;
         ex_imm         <= '0;
         ex_rs          <= '0;
         ex_rt          <= '0;
         ex_rd          <= '0;
         ex_opcode      <= '0;
         ex_funct       <= '0;
         ex_mem_read    <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (load_en) begin
         if (hazard || !if_valid) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid       <= 1'b1;
            ex_read_data_1 <= rdata_1_c;
            ex_read_data_2 <= rdata_2_c;
            ex_imm         <= imm_ext;
            ex_rs          <= rs;
            ex_rt          <= rt;
            ex_rd          <= rd;
            ex_opcode      <= opcode;
            ex_funct       <= funct;
            ex_mem_read    <= (opcode == OP_LW);
         end
      end
   end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed vector table, mid-stream reset, then random traffic vs a model.
module tb_id_stage_pipelined;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] instruction;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [31:0] ex_read_data_1;
   logic [31:0] ex_read_data_2;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_rd;
   logic [5:0]  ex_opcode;
   logic [5:0]  ex_funct;
   logic        ex_mem_read;
   logic        load_use_stall;

   id_stage_pipelined #(
      .DATA_W     (32),
      .REG_COUNT  (32),
      .ZEXT_LOGIC (1'b1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .instruction    (instruction),
      .wb_reg_write   (wb_reg_write),
      .wb_write_reg   (wb_write_reg),
      .wb_write_data  (wb_write_data),
      .flush          (flush),
      .ex_ready       (ex_ready),
      .ex_valid       (ex_valid),
      .ex_read_data_1 (ex_read_data_1),
      .ex_read_data_2 (ex_read_data_2),
      .ex_imm         (ex_imm),
      .ex_rs          (ex_rs),
      .ex_rt          (ex_rt),
      .ex_rd          (ex_rd),
      .ex_opcode      (ex_opcode),
      .ex_funct       (ex_funct),
      .ex_mem_read    (ex_mem_read),
      .load_use_stall (load_use_stall)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [31:0] instr;
      bit          iv, er, fl, we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      bit          x_ifr, x_stall, x_valid, chk_data;
      logic [31:0] x_rd1, x_rd2, x_imm;
      logic [4:0]  x_rs, x_rt, x_rd;
      logic [5:0]  x_funct;
      bit          x_memrd;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   // ---------------- reference model ----------------
   typedef struct {
      bit          valid;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  op, funct;
      bit          memrd;
   } ex_t;

   logic [31:0] m_regs [32];
   ex_t         m_ex;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_reg_write && wb_write_reg == a) return wb_write_data;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] ins);
      logic [5:0] op;
      op = ins[31:26];
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, ins[15:0]};
      return {{16{ins[15]}}, ins[15:0]};
   endfunction

   function automatic ex_t m_decode(input logic [31:0] ins);
      ex_t e;
      e.valid = 1'b1;
      e.op    = ins[31:26];
      e.rs    = ins[25:21];
      e.rt    = ins[20:16];
      e.rd    = ins[15:11];
      e.funct = ins[5:0];
      e.imm   = m_imm(ins);
      e.rd1   = m_read(e.rs);
      e.rd2   = m_read(e.rt);
      e.memrd = (e.op == 6'h23);
      return e;
   endfunction

   // One cycle under the model: check handshake outputs, clock, check ID/EX contents.
   task automatic model_cycle(input int n);
      bit   haz, len;
      ex_t  nx;
      #1;
      len = !m_ex.valid || ex_ready;
      haz = m_ex.valid && m_ex.memrd && m_ex.rt != 5'd0 && if_valid &&
            (m_ex.rt == instruction[25:21] || m_ex.rt == instruction[20:16]);
      chk($sformatf("rnd%0d_if_ready", n), 32'(if_ready), 32'(flush || (len && !haz)));
      chk($sformatf("rnd%0d_stall", n), 32'(load_use_stall), 32'(haz && len && !flush));
      nx = m_ex;
      if (flush) nx.valid = 1'b0;
      else if (len) begin
         if (haz || !if_valid) nx.valid = 1'b0;
         else nx = m_decode(instruction);
      end
      @(posedge clk);
      m_ex = nx;
      if (wb_reg_write && wb_write_reg != 5'd0) m_regs[wb_write_reg] = wb_write_data;
      #1;
      chk($sformatf("rnd%0d_valid", n), 32'(ex_valid), 32'(m_ex.valid));
      if (m_ex.valid) begin
         chk($sformatf("rnd%0d_rd1", n), ex_read_data_1, m_ex.rd1);
         chk($sformatf("rnd%0d_rd2", n), ex_read_data_2, m_ex.rd2);
         chk($sformatf("rnd%0d_imm", n), ex_imm, m_ex.imm);
         chk($sformatf("rnd%0d_fields", n),
             32'({ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct, ex_mem_read}),
             32'({m_ex.rs, m_ex.rt, m_ex.rd, m_ex.op, m_ex.funct, m_ex.memrd}));
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [7];
      logic [31:0] ins;
      ops = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0E};
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 6)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      return ins;
   endfunction

   initial begin
      vecs[0]  = '{32'h0, 0,1,0,1, 5'd9,  32'd5,    1,0,0,0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'h00, 0};
      vecs[1]  = '{32'h0, 0,1,0,1, 5'd10, 32'd3,    1,0,0,0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'h00, 0};
      vecs[2]  = '{32'h012A4020, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd5, 32'd3, 32'h4020, 5'd9, 5'd10, 5'd8, 6'h20, 0};
      vecs[3]  = '{32'h012A4020, 1,1,0,1, 5'd9, 32'd7, 1,0,1,1, 32'd7, 32'd3, 32'h4020, 5'd9, 5'd10, 5'd8, 6'h20, 0};
      vecs[4]  = '{32'h8D090004, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd0, 32'd7, 32'h4, 5'd8, 5'd9, 5'd0, 6'h04, 1};
      vecs[5]  = '{32'h012A4020, 1,1,0,0, 5'd0, 32'd0, 0,1,0,0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'h00, 0};
      vecs[6]  = '{32'h012A4020, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd7, 32'd3, 32'h4020, 5'd9, 5'd10, 5'd8, 6'h20, 0};
      vecs[7]  = '{32'h2008FFFD, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd0, 32'd0, 32'hFFFFFFFD, 5'd0, 5'd8, 5'd31, 6'h3D, 0};
      vecs[8]  = '{32'h3108FFFF, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd0, 32'd0, 32'h0000FFFF, 5'd8, 5'd8, 5'd31, 6'h3F, 0};
      vecs[9]  = '{32'h012A4020, 1,0,0,0, 5'd0, 32'd0, 0,0,1,1, 32'd0, 32'd0, 32'h0000FFFF, 5'd8, 5'd8, 5'd31, 6'h3F, 0};
      vecs[10] = '{32'h012A4020, 1,0,1,0, 5'd0, 32'd0, 1,0,0,0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'h00, 0};
      vecs[11] = '{32'h0, 0,1,0,1, 5'd0, 32'hDEAD, 1,0,0,0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'h00, 0};
      vecs[12] = '{32'h00004020, 1,1,0,1, 5'd0, 32'hDEAD, 1,0,1,1, 32'd0, 32'd0, 32'h4020, 5'd0, 5'd0, 5'd8, 6'h20, 0};
      vecs[13] = '{32'h34088000, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd0, 32'd0, 32'h00008000, 5'd0, 5'd8, 5'd16, 6'h00, 0};
      vecs[14] = '{32'h8D09FFFC, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd0, 32'd7, 32'hFFFFFFFC, 5'd8, 5'd9, 5'd31, 6'h3C, 1};
      vecs[15] = '{32'h012A4020, 1,0,0,0, 5'd0, 32'd0, 0,0,1,1, 32'd0, 32'd7, 32'hFFFFFFFC, 5'd8, 5'd9, 5'd31, 6'h3C, 1};
      vecs[16] = '{32'h012A4020, 1,1,1,0, 5'd0, 32'd0, 1,0,0,0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'h00, 0};
      vecs[17] = '{32'h012A4020, 1,1,0,0, 5'd0, 32'd0, 1,0,1,1, 32'd7, 32'd3, 32'h4020, 5'd9, 5'd10, 5'd8, 6'h20, 0};

      rst_n = 1'b0; if_valid = 1'b0; instruction = '0; wb_reg_write = 1'b0;
      wb_write_reg = '0; wb_write_data = '0; flush = 1'b0; ex_ready = 1'b1;
      #1;
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_rd1", ex_read_data_1, 32'd0);
      chk("reset_imm", ex_imm, 32'd0);
      chk("reset_if_ready", 32'(if_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         instruction   = vecs[i].instr;
         if_valid      = vecs[i].iv;
         ex_ready      = vecs[i].er;
         flush         = vecs[i].fl;
         wb_reg_write  = vecs[i].we;
         wb_write_reg  = vecs[i].wreg;
         wb_write_data = vecs[i].wdata;
         #1;
         chk($sformatf("vec%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].x_ifr));
         chk($sformatf("vec%0d_stall", i), 32'(load_use_stall), 32'(vecs[i].x_stall));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].x_valid));
         if (vecs[i].chk_data) begin
            chk($sformatf("vec%0d_rd1", i), ex_read_data_1, vecs[i].x_rd1);
            chk($sformatf("vec%0d_rd2", i), ex_read_data_2, vecs[i].x_rd2);
            chk($sformatf("vec%0d_imm", i), ex_imm, vecs[i].x_imm);
            chk($sformatf("vec%0d_rs", i), 32'(ex_rs), 32'(vecs[i].x_rs));
            chk($sformatf("vec%0d_rt", i), 32'(ex_rt), 32'(vecs[i].x_rt));
            chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vecs[i].x_rd));
            chk($sformatf("vec%0d_funct", i), 32'(ex_funct), 32'(vecs[i].x_funct));
            chk($sformatf("vec%0d_memrd", i), 32'(ex_mem_read), 32'(vecs[i].x_memrd));
         end
      end

      // Reset mid-stream while the add is still held in ID/EX.
      if_valid = 1'b0; wb_reg_write = 1'b0; flush = 1'b0; ex_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(ex_valid), 32'd0);
      chk("midrst_rd1", ex_read_data_1, 32'd0);
      chk("midrst_rd2", ex_read_data_2, 32'd0);
      chk("midrst_imm", ex_imm, 32'd0);
      chk("midrst_fields", 32'({ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct, ex_mem_read}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
      m_ex = '{default: 0};

      // Register 9 was cleared by the reset; read it back through a fresh add.
      instruction = 32'h012A4020; if_valid = 1'b1; ex_ready = 1'b1;
      model_cycle(-1);
      chk("postrst_reg9", ex_read_data_1, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         instruction   = rand_instr();
         if_valid      = ($urandom_range(0, 3) != 0);
         ex_ready      = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 15) == 0);
         wb_reg_write  = ($urandom_range(0, 1) == 1);
         wb_write_reg  = 5'($urandom_range(0, 9));
         wb_write_data = $urandom;
         model_cycle(n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
